// File: rtl/score_keeper_if.sv
// Bus between the game logic and score_keeper: goal pulses and the restart
// button in, scores, win status and ball-release control out.
// Pulse semantics: goal_p1/goal_p2 are single-cycle strobes sampled on clk
// and have no back-pressure. serve is a single-cycle strobe that releases the
// ball. All outputs are registered. dbg_state mirrors the FSM state.
interface score_keeper_if;
  logic       goal_p1;
  logic       goal_p2;
  logic       restart;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       game_over;
  logic       winner;
  logic       ball_freeze;
  logic       serve;
  logic       serve_dir;
  logic [1:0] dbg_state;

  modport master (
    output goal_p1, goal_p2, restart,
    input  score_p1, score_p2, game_over, winner, ball_freeze, serve,
           serve_dir, dbg_state
  );

  modport slave (
    input  goal_p1, goal_p2, restart,
    output score_p1, score_p2, game_over, winner, ball_freeze, serve,
           serve_dir, dbg_state
  );
endinterface

// File: rtl/score_keeper.sv
// score_keeper: counts goals, detects the win, times the serve pause and
// handles a synchronised restart button. Every output is a flop.
module score_keeper #(
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           reset,
  score_keeper_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  localparam int            CW         = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(PAUSE_CYCLES - 1);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_score_p1, w_score_p1_nxt;
  logic [3:0]    r_score_p2, w_score_p2_nxt;
  logic          r_game_over, w_game_over_nxt;
  logic          r_winner, w_winner_nxt;
  logic          r_ball_freeze, w_ball_freeze_nxt;
  logic          r_serve, w_serve_nxt;
  logic          r_serve_dir, w_serve_dir_nxt;
  logic          r_sync1, r_sync2, r_prev;
  logic          w_restart_edge;
  logic [3:0]    w_p1_inc, w_p2_inc;

  // Rising edge of the synchronised button; a held button yields one edge.
  assign w_restart_edge = r_sync2 & ~r_prev;
  assign w_p1_inc       = r_score_p1 + 4'd1;
  assign w_p2_inc       = r_score_p2 + 4'd1;

  // Two-flop synchroniser plus previous-value flop for the restart button.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= bus.restart;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Next-state and next-output logic; restart overrides everything but reset.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_score_p1_nxt    = r_score_p1;
    w_score_p2_nxt    = r_score_p2;
    w_game_over_nxt   = r_game_over;
    w_winner_nxt      = r_winner;
    w_ball_freeze_nxt = r_ball_freeze;
    w_serve_nxt       = 1'b0;
    w_serve_dir_nxt   = r_serve_dir;
    if (w_restart_edge) begin
      w_state_nxt       = ST_SERVE;
      w_cnt_nxt         = CNT_RELOAD;
      w_score_p1_nxt    = 4'd0;
      w_score_p2_nxt    = 4'd0;
      w_game_over_nxt   = 1'b0;
      w_winner_nxt      = 1'b0;
      w_serve_dir_nxt   = 1'b0;
      w_ball_freeze_nxt = 1'b1;
    end else begin
      case (r_state)
        ST_SERVE: begin
          if (r_cnt == '0) begin
            w_serve_nxt       = 1'b1;
            w_ball_freeze_nxt = 1'b0;
            w_state_nxt       = ST_PLAY;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        ST_PLAY: begin
          if (bus.goal_p1 && !bus.goal_p2) begin
            w_score_p1_nxt    = w_p1_inc;
            w_ball_freeze_nxt = 1'b1;
            if (w_p1_inc == WIN) begin
              w_state_nxt     = ST_OVER;
              w_game_over_nxt = 1'b1;
              w_winner_nxt    = 1'b0;
            end else begin
              w_state_nxt     = ST_SERVE;
              w_cnt_nxt       = CNT_RELOAD;
              w_serve_dir_nxt = 1'b1;
            end
          end else if (bus.goal_p2 && !bus.goal_p1) begin
            w_score_p2_nxt    = w_p2_inc;
            w_ball_freeze_nxt = 1'b1;
            if (w_p2_inc == WIN) begin
              w_state_nxt     = ST_OVER;
              w_game_over_nxt = 1'b1;
              w_winner_nxt    = 1'b1;
            end else begin
              w_state_nxt     = ST_SERVE;
              w_cnt_nxt       = CNT_RELOAD;
              w_serve_dir_nxt = 1'b0;
            end
          end else if (bus.goal_p1 && bus.goal_p2) begin
            // Simultaneous goals: no point awarded, just re-serve.
            w_state_nxt       = ST_SERVE;
            w_cnt_nxt         = CNT_RELOAD;
            w_ball_freeze_nxt = 1'b1;
          end
        end
        ST_OVER: begin
          w_ball_freeze_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = ST_SERVE;
          w_cnt_nxt   = CNT_RELOAD;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_SERVE;
      r_cnt         <= CNT_RELOAD;
      r_score_p1    <= 4'd0;
      r_score_p2    <= 4'd0;
      r_game_over   <= 1'b0;
      r_winner      <= 1'b0;
      r_ball_freeze <= 1'b1;
      r_serve       <= 1'b0;
      r_serve_dir   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_score_p1    <= w_score_p1_nxt;
      r_score_p2    <= w_score_p2_nxt;
      r_game_over   <= w_game_over_nxt;
      r_winner      <= w_winner_nxt;
      r_ball_freeze <= w_ball_freeze_nxt;
      r_serve       <= w_serve_nxt;
      r_serve_dir   <= w_serve_dir_nxt;
    end
  end

  assign bus.score_p1    = r_score_p1;
  assign bus.score_p2    = r_score_p2;
  assign bus.game_over   = r_game_over;
  assign bus.winner      = r_winner;
  assign bus.ball_freeze = r_ball_freeze;
  assign bus.serve       = r_serve;
  assign bus.serve_dir   = r_serve_dir;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_score_keeper.sv
// Testbench for score_keeper with WIN_SCORE=3, PAUSE_CYCLES=4.
module tb_score_keeper;

  localparam int WIN   = 3;
  localparam int PAUSE = 4;

  localparam int MODE_PAUSE = 0;
  localparam int MODE_PLAY  = 1;
  localparam int MODE_OVER  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  score_keeper_if bus ();

  score_keeper #(.WIN_SCORE(WIN), .PAUSE_CYCLES(PAUSE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: game-level view of the rules.
  int m_s1, m_s2;
  int m_mode;
  int m_wait;     // edges left in the pause until the serve pulse
  bit m_win, m_dir, m_serve;
  bit rs_q[$];    // last three raw restart samples, oldest first

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_mode = MODE_PAUSE; m_wait = PAUSE;
    m_win = 0; m_dir = 0; m_serve = 0;
    rs_q = '{0, 0, 0};
  endtask

  task automatic enter_pause();
    m_mode = MODE_PAUSE;
    m_wait = PAUSE;
  endtask

  task automatic award(input int who);
    if (who == 1) m_s1++; else m_s2++;
    if ((who == 1 ? m_s1 : m_s2) == WIN) begin
      m_mode = MODE_OVER;
      m_win  = (who == 2);
    end else begin
      enter_pause();
      m_dir = (who == 1);   // serve toward the player who lost the point
    end
  endtask

  task automatic model_step(input bit rst, input bit g1, input bit g2, input bit rs);
    bit fire;
    m_serve = 0;
    if (rst) begin
      model_reset();
      return;
    end
    // button sampled two edges ago high, three edges ago low
    fire = rs_q[1] && !rs_q[0];
    void'(rs_q.pop_front());
    rs_q.push_back(rs);
    if (fire) begin
      m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0;
      enter_pause();
    end else if (m_mode == MODE_PAUSE) begin
      m_wait--;
      if (m_wait == 0) begin
        m_serve = 1;
        m_mode  = MODE_PLAY;
      end
    end else if (m_mode == MODE_PLAY) begin
      if (g1 && g2) enter_pause();
      else if (g1)  award(1);
      else if (g2)  award(2);
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (vector %0d)", tag, obs, exp, vectors);
    end
  endtask

  // Driver: apply one cycle of inputs, advance model, compare outputs.
  task automatic step(input bit rst, input bit g1, input bit g2, input bit rs);
    reset       = rst;
    bus.goal_p1 = g1;
    bus.goal_p2 = g2;
    bus.restart = rs;
    @(posedge clk);
    model_step(rst, g1, g2, rs);
    #1;
    vectors++;
    chk("score_p1",    bus.score_p1,           4'(m_s1));
    chk("score_p2",    bus.score_p2,           4'(m_s2));
    chk("game_over",   {3'b0, bus.game_over},  {3'b0, m_mode == MODE_OVER});
    chk("winner",      {3'b0, bus.winner},     {3'b0, m_win});
    chk("ball_freeze", {3'b0, bus.ball_freeze},{3'b0, m_mode != MODE_PLAY});
    chk("serve",       {3'b0, bus.serve},      {3'b0, m_serve});
    chk("serve_dir",   {3'b0, bus.serve_dir},  {3'b0, m_dir});
    chk("serve_while_over", {3'b0, bus.serve & bus.game_over}, 4'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  // Bounded wait until the model says the ball is in play.
  task automatic wait_play();
    int n = 0;
    while (m_mode != MODE_PLAY && n < 100) begin
      step(0, 0, 0, 0);
      n++;
    end
    assert (m_mode == MODE_PLAY) else begin
      miscompares++;
      $error("FAIL wait_play: observed timeout after %0d cycles expected play", n);
    end
  endtask

  initial begin
    bus.goal_p1 = 0; bus.goal_p2 = 0; bus.restart = 0;
    model_reset();

    // Reset, then the first serve PAUSE cycles later
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    idle(PAUSE + 2);

    // Player 1 scores; goals during the pause are ignored
    step(0, 1, 0, 0);
    for (int i = 0; i < PAUSE - 1; i++)
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    wait_play();
    idle(2);

    // Simultaneous goals: no score change, re-serve
    step(0, 1, 1, 0);
    wait_play();

    // Player 2 wins with three goals
    for (int k = 0; k < WIN; k++) begin
      wait_play();
      idle($urandom_range(0, 3));
      step(0, 0, 1, 0);
    end
    step(0, 1, 0, 0);
    idle(PAUSE + 3);

    // Restart held for 20 cycles in OVER
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
    idle(PAUSE + 3);

    // Reach 2:1, then restart with a goal on the action edge
    wait_play(); step(0, 1, 0, 0);
    wait_play(); step(0, 1, 0, 0);
    wait_play(); step(0, 0, 1, 0);
    wait_play(); idle(1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    step(0, 0, 0, 0);

    // Reset in the middle of the serve pause
    idle(2);
    step(1, 0, 0, 0);
    idle(PAUSE + 2);

    // Random soak
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 199) == 0),
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 29) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
Game-side writer of the 4-bit player scores that the seven-segment score display multiplexes. It counts goal events and detects the win. It sequences the serve pause after each point and the freeze at game over. It also handles a restart button. It drives score_p1/score_p2 directly into the display block and controls ball release in the game logic.

Parameters:
WIN_SCORE, 9, score at which a game ends; the display blinks at this value; legal range 1..15
PAUSE_CYCLES, 1000, clk cycles the ball stays frozen before each serve; must be >= 1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
goal_p1  input  1  one-cycle pulse: player 1 scored (ball exited on player 2's side)
goal_p2  input  1  one-cycle pulse: player 2 scored
restart  input  1  raw button, asynchronous to clk, active-high
score_p1  output  4  player 1 score, 0..WIN_SCORE
score_p2  output  4  player 2 score, 0..WIN_SCORE
game_over  output  1  high while in OVER
winner  output  1  0 = player 1 won, 1 = player 2 won; valid only while game_over
ball_freeze  output  1  high in SERVE and OVER; the game holds the ball at centre
serve  output  1  one-cycle pulse that releases the ball
serve_dir  output  1  0 = ball launches toward player 1, 1 = toward player 2

Behaviour:
- All outputs are registered.
- Reset, sampled on a clk edge with reset high, sets the following:
  - score_p1 = 0, score_p2 = 0
  - game_over = 0, winner = 0, serve = 0, serve_dir = 0, ball_freeze = 1
  - state = SERVE, pause counter = PAUSE_CYCLES-1
  - synchronizer flops = 0
- Reset has priority over everything, including in-flight goals and restart.
- Restart synchronization:
  - 2-flop synchronizer followed by a previous-value flop.
  - restart_edge = sync2 & ~prev.
  - The action takes effect on the 3rd clk edge after restart is first sampled high.
  - Holding the button produces exactly one edge.
- State SERVE:
  - Counter decrements by 1 each cycle; goal inputs are ignored.
  - When the counter is 0: serve = 1 for that one cycle, ball_freeze drops to 0 on the same edge, next state = PLAY.
  - Total time from entering SERVE to the serve pulse is PAUSE_CYCLES cycles.
- State PLAY:
  - goal_p1 & ~goal_p2: score_p1 increments on the sampling edge.
    - If the new value equals WIN_SCORE: go to OVER, winner = 0.
    - Otherwise: go to SERVE with serve_dir = 1 (serve toward the player who lost the point), counter reloaded.
  - goal_p2 & ~goal_p1: symmetric; winner = 1 on a win, serve_dir = 0 on a serve.
  - goal_p1 & goal_p2 together: neither score changes, serve_dir unchanged, go to SERVE.
  - ball_freeze is set to 1 on the same edge as the transition.
- State OVER:
  - Scores held, game_over = 1, ball_freeze = 1.
  - Goals are ignored; stays in OVER indefinitely until restart_edge.
- restart_edge in any state: both scores to 0, game_over = 0, winner = 0, serve_dir = 0, counter reloaded, state = SERVE.
  - Restart overrides a goal sampled in the same cycle.
- Scores never exceed WIN_SCORE; no wrap-around is possible.
- A goal held high for several cycles counts once, because the block leaves PLAY after the first cycle.
- serve is never high in two consecutive cycles.
- serve is never high while game_over is high.

Test Plan:
- Reset, then wait -> ball_freeze = 1 and scores 0/0. serve pulses exactly once, PAUSE_CYCLES cycles after reset deasserts. Next cycle ball_freeze = 0.
- In PLAY, pulse goal_p1 -> score_p1 = 1 the next cycle, serve_dir = 1, ball_freeze = 1. Further goal pulses during the pause leave scores unchanged. The serve pulse follows PAUSE_CYCLES cycles later.
- With WIN_SCORE = 3, PAUSE_CYCLES = 4, give player 2 three goals -> score_p2 = 3, game_over = 1, winner = 1, no further serve pulses. A goal_p1 while in OVER leaves score_p1 unchanged.
- goal_p1 and goal_p2 high in the same PLAY cycle -> scores unchanged, serve_dir unchanged, SERVE entered, serve after PAUSE_CYCLES.
- In OVER, hold restart high for 20 cycles -> exactly one clear, 3 edges after first sample. Result: scores 0/0, game_over = 0, exactly one serve after PAUSE_CYCLES.
- Assert restart mid-PLAY at score 2:1, with a goal arriving on the action edge -> scores 0/0, restart wins. Assert reset mid-SERVE -> counter reloads and the serve timing restarts from the reset.
